// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key schedule and round datapaths.
// Contents: round/word constants, word and key types, key-schedule FSM
// states, the GF(2^8) xtime helper and the initial round constant.
package aes_pkg;

    localparam int unsigned AES_NR   = 10;
    localparam int unsigned AES_NK   = 4;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned KEY_W    = AES_NK * WORD_W;
    localparam int unsigned RK_NUM   = AES_NR + 1;
    localparam int unsigned ROUND_W  = 4;

    typedef logic [WORD_W-1:0] aes_word_t;
    typedef logic [KEY_W-1:0]  aes_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Combinational forward AES S-box (SubBytes) for one byte.
// Ports: x - input byte, s - substituted byte.
module aes_sbox_fwd (
    input  logic [7:0] x,
    output logic [7:0] s
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[x];

endmodule

// File: rtl/aes_key_expand.sv
// Forward AES-128 key schedule: expands key_in into round keys 0..10, one
// round per cycle, and stores them for random-access reads.
// Ports: clk, rst (sync, active-high), start/key_in (expansion request),
//        busy/done (status), rk_rd_idx/rk_rd_data (registered read port,
//        1-cycle latency, idx > 10 reads 0), last_key (round key 10, direct).
module aes_key_expand
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key_in,
    output logic                 busy,
    output logic                 done,
    input  logic [ROUND_W-1:0]   rk_rd_idx,
    output logic [KEY_W-1:0]     rk_rd_data,
    output logic [KEY_W-1:0]     last_key
);

    ks_state_t          state;
    logic [ROUND_W-1:0] round;
    logic [7:0]         rcon;
    aes_key_t           rk [RK_NUM];

    logic [ROUND_W-1:0] prev_idx;
    aes_key_t           prev_key;
    aes_word_t          w0, w1, w2, w3;
    aes_word_t          rot_w3, sub_w3, t_word;
    aes_word_t          n0, n1, n2, n3;
    aes_key_t           next_key;

    // Previous round key; round is 1..10 whenever it is consumed.
    always_comb begin
        prev_idx = (round == '0) ? '0 : round - ROUND_W'(1);
        prev_key = rk[prev_idx];
        {w0, w1, w2, w3} = prev_key;
        rot_w3 = {w3[23:0], w3[31:24]};
    end

    // SubWord over RotWord(w3), one S-box per byte.
    for (genvar g = 0; g < int'(AES_NK); g++) begin : g_subword
        aes_sbox_fwd u_sbox (
            .x (rot_w3[8*g +: 8]),
            .s (sub_w3[8*g +: 8])
        );
    end

    always_comb begin
        t_word   = sub_w3 ^ {rcon, 24'h0};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Control FSM, key storage and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            round      <= '0;
            rcon       <= RCON_INIT;
            busy       <= 1'b0;
            done       <= 1'b0;
            rk_rd_data <= '0;
            for (int i = 0; i < int'(RK_NUM); i++) begin
                rk[i] <= '0;
            end
        end else begin
            rk_rd_data <= (rk_rd_idx <= ROUND_W'(AES_NR)) ? rk[rk_rd_idx] : '0;
            done       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rk[0] <= key_in;
                        round <= ROUND_W'(1);
                        rcon  <= RCON_INIT;
                        busy  <= 1'b1;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[round] <= next_key;
                    rcon      <= xtime(rcon);
                    round     <= round + ROUND_W'(1);
                    if (round == ROUND_W'(AES_NR)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign last_key = rk[AES_NR];

endmodule
